// File: rtl/coin_acceptor.sv
// coin_acceptor_channel: one coin sensor path. Two-flop synchronizer, debouncer
// and saturating pending-credit counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous, possibly bouncing sensor line (active-high)
//   take       : release of one credit from this channel on this edge
//   pend       : current pending credit count
//   ovf_c      : combinational; insertion hit a full counter on this edge
module coin_acceptor_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PEND_MAX        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  input  logic       take,
  output logic [2:0] pend,
  output logic       ovf_c
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PEND_W = 3;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

  logic             sync1;
  logic             s;
  logic             d;
  logic [CNT_W-1:0] cnt;
  logic             rise_c;
  logic             full_c;

  // Two-stage synchronizer; only the second stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // The level flips on the edge where the mismatch count would reach
  // DEBOUNCE_CYCLES, so the insertion is visible on that same edge.
  assign rise_c = s && !d && (cnt == CNT_LAST);
  assign full_c = (pend == PEND_TOP);
  assign ovf_c  = rise_c && !take && full_c;

  // Debouncer: any agreement between s and d restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d   <= 1'b0;
      cnt <= '0;
    end else if (s != d) begin
      if (cnt == CNT_LAST) begin
        d   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Pending counter; simultaneous insertion and release cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (rise_c && !take) begin
      if (!full_c) begin
        pend <= pend + PEND_W'(1);
      end
    end else if (take && !rise_c) begin
      pend <= pend - PEND_W'(1);
    end
  end

endmodule

// coin_acceptor: conditions two raw coin sensors into credit pulses for the
// vending controller. Credits queue while hold (controller dispense) is high.
//   clk, rst_n     : clock, asynchronous active-low reset
//   raw5, raw10    : asynchronous coin sensor lines
//   hold           : release inhibit
//   coin5, coin10  : registered one-cycle credit pulses, never together
//   pend5, pend10  : pending credit counts
//   overflow       : sticky, an insertion found its counter saturated
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PEND_MAX        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw5,
  input  logic       raw10,
  input  logic       hold,
  output logic       coin5,
  output logic       coin10,
  output logic [2:0] pend5,
  output logic [2:0] pend10,
  output logic       overflow
);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_GAP  = 1'b1
  } arb_state_t;

  arb_state_t state;
  logic       take5_c;
  logic       take10_c;
  logic       ovf5_c;
  logic       ovf10_c;

  coin_acceptor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PEND_MAX        (PEND_MAX)
  ) u_ch5 (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw5),
    .take  (take5_c),
    .pend  (pend5),
    .ovf_c (ovf5_c)
  );

  coin_acceptor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PEND_MAX        (PEND_MAX)
  ) u_ch10 (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw10),
    .take  (take10_c),
    .pend  (pend10),
    .ovf_c (ovf10_c)
  );

  // Release decision: 10-unit credits first; nothing during the gap cycle
  // that follows a pulse, so dispense has time to assert.
  assign take10_c = (state == ARB_IDLE) && !hold && (pend10 != 3'd0);
  assign take5_c  = (state == ARB_IDLE) && !hold && (pend10 == 3'd0) &&
                    (pend5 != 3'd0);

  // Release arbiter with registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      coin5  <= 1'b0;
      coin10 <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          coin10 <= take10_c;
          coin5  <= take5_c;
          if (take10_c || take5_c) begin
            state <= ARB_GAP;
          end
        end
        ARB_GAP: begin
          coin10 <= 1'b0;
          coin5  <= 1'b0;
          state  <= ARB_IDLE;
        end
        default: begin
          coin10 <= 1'b0;
          coin5  <= 1'b0;
          state  <= ARB_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf5_c || ovf10_c) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4, PEND_MAX=3.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       raw5;
  logic       raw10;
  logic       hold;
  logic       coin5;
  logic       coin10;
  logic [2:0] pend5;
  logic [2:0] pend10;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n5, n10, both, consec;
  int first5, last5, last10;
  bit prev_pulse;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (4),
    .PEND_MAX        (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw5     (raw5),
    .raw10    (raw10),
    .hold     (hold),
    .coin5    (coin5),
    .coin10   (coin10),
    .pend5    (pend5),
    .pend10   (pend10),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (coin5) begin
        if (n5 == 0) first5 = cyc;
        last5 = cyc;
        n5++;
      end
      if (coin10) begin
        last10 = cyc;
        n10++;
      end
      if (coin5 && coin10) both++;
      if ((coin5 || coin10) && prev_pulse) consec++;
      prev_pulse = coin5 || coin10;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon;
    n5 = 0; n10 = 0; both = 0; consec = 0;
    first5 = -1; last5 = -1; last10 = -1;
  endtask

  // One clean insertion on a channel: high for hi cycles, then low for lo.
  task automatic coin_in(input bit ch10, input int hi, input int lo);
    if (ch10) raw10 = 1'b1; else raw5 = 1'b1;
    tick(hi);
    if (ch10) raw10 = 1'b0; else raw5 = 1'b0;
    tick(lo);
  endtask

  initial begin
    rst_n = 1'b0; raw5 = 1'b0; raw10 = 1'b0; hold = 1'b0;
    clear_mon();
    #2;
    check("rst_coin5", 32'(coin5), 0);
    check("rst_coin10", 32'(coin10), 0);
    check("rst_pend5", 32'(pend5), 0);
    check("rst_pend10", 32'(pend10), 0);
    check("rst_ovf", 32'(overflow), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Clean coin5, raw rises just before edge k.
    clear_mon();
    raw5 = 1'b1;
    tick(5);
    check("t1_pend_k4", 32'(pend5), 0);
    tick(1);
    check("t1_pend_k5", 32'(pend5), 1);
    check("t1_coin_k5", 32'(coin5), 0);
    tick(1);
    check("t1_pend_k6", 32'(pend5), 0);
    check("t1_coin_k6", 32'(coin5), 1);
    tick(1);
    check("t1_coin_k7", 32'(coin5), 0);
    tick(2);
    raw5 = 1'b0;
    tick(10);
    check("t1_n5", 32'(n5), 1);
    check("t1_n10", 32'(n10), 0);

    // Bounce rejection: 3 high / 1 low, four times.
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      raw10 = 1'b1;
      tick(3);
      raw10 = 1'b0;
      tick(1);
    end
    tick(1);
    check("t2_pend_bounce", 32'(pend10), 0);
    check("t2_n10_bounce", 32'(n10), 0);
    raw10 = 1'b1;
    tick(10);
    raw10 = 1'b0;
    tick(10);
    check("t2_n10", 32'(n10), 1);
    check("t2_pend", 32'(pend10), 0);

    // Hold deferral.
    clear_mon();
    hold = 1'b1;
    coin_in(1'b0, 8, 8);
    coin_in(1'b0, 8, 8);
    check("t3_pend_held", 32'(pend5), 2);
    check("t3_n5_held", 32'(n5), 0);
    hold = 1'b0;
    tick(8);
    check("t3_n5", 32'(n5), 2);
    check("t3_spacing", 32'(last5 - first5), 2);
    check("t3_pend_end", 32'(pend5), 0);

    // Simultaneous coins.
    clear_mon();
    raw5 = 1'b1;
    raw10 = 1'b1;
    tick(10);
    raw5 = 1'b0;
    raw10 = 1'b0;
    tick(10);
    check("t4_n10", 32'(n10), 1);
    check("t4_n5", 32'(n5), 1);
    check("t4_order", 32'(last5 - last10), 2);
    check("t4_both", 32'(both), 0);

    // Saturation at PEND_MAX=3.
    clear_mon();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      coin_in(1'b1, 8, 8);
      check($sformatf("t5_pend_%0d", i), 32'(pend10), (i < 3) ? i + 1 : 3);
      check($sformatf("t5_ovf_%0d", i), 32'(overflow), (i == 3) ? 1 : 0);
    end
    hold = 1'b0;
    tick(12);
    check("t5_n10", 32'(n10), 3);
    check("t5_pend_end", 32'(pend10), 0);
    check("t5_ovf_sticky", 32'(overflow), 1);
    check("gap_consec", 32'(consec), 0);

    // Mid-operation asynchronous reset.
    hold = 1'b1;
    coin_in(1'b0, 8, 8);
    coin_in(1'b0, 8, 8);
    check("t6_pend_pre", 32'(pend5), 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_pend5", 32'(pend5), 0);
    check("t6_pend10", 32'(pend10), 0);
    check("t6_ovf", 32'(overflow), 0);
    check("t6_coins", 32'({coin5, coin10}), 0);
    tick(3);
    rst_n = 1'b1;
    hold = 1'b0;
    clear_mon();
    tick(20);
    check("t6_no_pulse", 32'(n5 + n10), 0);
    check("t6_pend_after", 32'(pend5), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin conditioning stage that drives the `coin5`/`coin10` inputs of the vending controller. It synchronizes the two raw coin-sensor lines, debounces them, and converts each debounced insertion into a pending credit. Credits are released as single-cycle, mutually exclusive pulses, and only while the controller is not dispensing. Coins that arrive while the product is being dispensed are therefore never lost.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples required before a level change is accepted. Legal range 1..255.
- `PEND_MAX`, default 3: saturation limit of each per-coin pending counter. Legal range 1..7; counters are 3 bits wide.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `raw5` input 1: asynchronous 5-unit coin sensor, active-high, may bounce.
- `raw10` input 1: asynchronous 10-unit coin sensor, active-high, may bounce.
- `hold` input 1: release inhibit; wired to the controller's `dispense`.
- `coin5` output 1: registered one-cycle pulse, one 5-unit credit.
- `coin10` output 1: registered one-cycle pulse, one 10-unit credit.
- `pend5` output 3: current 5-unit pending count.
- `pend10` output 3: current 10-unit pending count.
- `overflow` output 1: sticky; set when an insertion finds its counter at `PEND_MAX`. Cleared only by reset.

## Operation

Each coin channel is processed independently; the channels share only the release arbiter.

Synchronizer:
- Two flops per raw line.
- Only the second-stage outputs `s5` and `s10` are used downstream.

Debouncer (one per channel):
- Holds a debounced level `d`, reset value 0.
- Holds a counter, reset value 0, wide enough for `DEBOUNCE_CYCLES`.
- When `s != d`: the counter increments. On the edge where it would reach `DEBOUNCE_CYCLES`, `d` takes the value of `s` and the counter clears.
- When `s == d`: the counter clears. Any glitch shorter than `DEBOUNCE_CYCLES` samples is rejected.
- A rising edge of `d` (0→1) is one insertion. A falling edge produces no event.
- A sensor held high through reset release counts as one insertion once debounced.

Pending counters (one per channel):
- On insertion with count below `PEND_MAX`: count +1.
- On insertion with count at `PEND_MAX`: count unchanged and `overflow` is set.
- On release of that channel: count −1.
- Insertion and release on the same edge: net count unchanged; `overflow` is not set, even at `PEND_MAX`.

Release arbiter (registered):
- At each edge, if `hold == 0` and at least one count is nonzero, exactly one pulse is asserted for the next cycle.
- Priority is `pend10` over `pend5`.
- If `hold == 1`: no pulse; counts hold, apart from new insertions.
- Never `coin5 && coin10`.
- Pulses are never asserted on consecutive cycles. After a pulse cycle the arbiter waits one cycle, so the controller's registered `dispense` can assert before the next release.

Reset (asynchronous, any time):
- Clears both synchronizers, both `d` levels, the debounce counters, pending counts, `coin5`, `coin10` and `overflow`.
- Pending credits are discarded.

## Timing

Reset values:
- `coin5`, `coin10`, `overflow` = 0.
- `pend5`, `pend10` = 0.

Insertion latency (D = `DEBOUNCE_CYCLES`, clean raw rise before edge k):
- `s` is high after edge k+1.
- `d` rises and pend increments at edge k+1+D.
- The pulse is high for the cycle after edge k+2+D.
- With D = 4: pulse after edge k+6, provided `hold` is 0 at edge k+6 and the arbiter is not in its gap cycle.

Release spacing:
- Minimum 2 cycles between pulses.
- The `hold` value sampled at the releasing edge is what gates release.

Outputs:
- `pend5` and `pend10` update on the same edge as the event that changes them.
- `overflow` sets on the insertion edge.

## Test plan

- **Clean coin5:** `raw5` high 10 cycles, D=4, `hold`=0 → `pend5` goes 1 at edge k+5 and back to 0 at edge k+6; `coin5` is high exactly one cycle, after edge k+6; `coin10` stays 0.
- **Bounce rejection:** `raw10` toggles with 3-cycle high / 1-cycle low ×4, then holds high → no insertion during the bouncing; exactly one `coin10` pulse after the stable high.
- **Hold deferral:** two coin5 insertions while `hold`=1 → `pend5`=2, no pulses; drop `hold` → two `coin5` pulses two cycles apart; `pend5` ends at 0.
- **Simultaneous coins:** `raw5` and `raw10` rise on the same cycle → `coin10` pulses first, `coin5` two cycles later; the two pulses never overlap.
- **Saturation:** four coin10 insertions with `hold`=1, `PEND_MAX`=3 → `pend10`=3 and `overflow`=1; release yields exactly 3 pulses; `overflow` stays 1.
- **Mid-operation reset:** `pend5`=2 with `hold`=1, assert `rst_n`=0 asynchronously between edges → all outputs are 0 immediately; after release with raw lines low, no pulses ever appear.
